// File: rtl/raster_sequencer_if.sv
// Run control, vertex-memory read port and pixel stream of the raster sequencer.
// The sequencer drives through the master modport; the environment uses slave.
interface raster_sequencer_if #(
   parameter int ADDR_W  = 20,
   parameter int COLOR_W = 8
);
   logic                start;
   logic [15:0]         n_tri;
   logic                busy;
   logic                done;

   logic                vtx_rd;
   logic [ADDR_W-1:0]   vtx_addr;
   logic signed [31:0]  vtx_rdata;

   logic                pix_valid;
   logic                pix_ready;
   logic [11:0]         pix_x;
   logic [11:0]         pix_y;
   logic [COLOR_W-1:0]  pix_color;
   logic                pix_clear;

   logic signed [31:0]  tri_v1x;
   logic signed [31:0]  tri_v1y;
   logic signed [31:0]  tri_v2x;
   logic signed [31:0]  tri_v2y;
   logic signed [31:0]  tri_v3x;
   logic signed [31:0]  tri_v3y;

   modport master (
      input  start, n_tri, vtx_rdata, pix_ready,
      output busy, done, vtx_rd, vtx_addr,
             pix_valid, pix_x, pix_y, pix_color, pix_clear,
             tri_v1x, tri_v1y, tri_v2x, tri_v2y, tri_v3x, tri_v3y
   );

   modport slave (
      output start, n_tri, vtx_rdata, pix_ready,
      input  busy, done, vtx_rd, vtx_addr,
             pix_valid, pix_x, pix_y, pix_color, pix_clear,
             tri_v1x, tri_v1y, tri_v2x, tri_v2y, tri_v3x, tri_v3y
   );
endinterface

// File: rtl/raster_sequencer.sv
// Triangle rasterizer scheduler: fetch, bound, clamp and scan each triangle's box.
// Optional framebuffer clear before the first fetch: define RASTER_SEQ_CLEAR_EN.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | streaming clear beats over the whole framebuffer (RASTER_SEQ_CLEAR_EN only)
// FETCH | reading six vertex words of the current triangle
// SETUP | bounding box, clamp, degenerate test
// SCAN  | streaming candidate pixels of the box
// NEXT  | advance triangle index
// DONE  | one-cycle done pulse
module raster_sequencer #(
   parameter int FB_W       = 800,
   parameter int FB_H       = 600,
   parameter int X_OFS      = 400,
   parameter int Y_OFS      = 300,
   parameter int ADDR_W     = 20,
   parameter int COLOR_W    = 8,
   parameter int COLOR_INIT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   raster_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
`ifdef RASTER_SEQ_CLEAR_EN
      ST_CLEAR,
`endif
      ST_FETCH,
      ST_SETUP,
      ST_SCAN,
      ST_NEXT,
      ST_DONE
   } state_t;

   localparam logic signed [31:0] X_MAX = 32'(FB_W - 1);
   localparam logic signed [31:0] Y_MAX = 32'(FB_H - 1);
   localparam logic [COLOR_W-1:0] C_INIT = COLOR_W'(COLOR_INIT);

   state_t              state;
   logic                busy_q;
   logic                done_q;
   logic                vtx_rd_q;
   logic [ADDR_W-1:0]   vtx_addr_q;
   logic                rd_d;
   logic [2:0]          fcnt;
   logic [2:0]          cap_idx;
   logic signed [31:0]  vtx_q [0:5];
   logic [15:0]         n_tri_q;
   logic [15:0]         tri_idx;
   logic [COLOR_W-1:0]  color_q;
   logic                pix_valid_q;
   logic [11:0]         pix_x_q;
   logic [11:0]         pix_y_q;
   logic [COLOR_W-1:0]  pix_color_q;
   logic [11:0]         tl_x_q;
   logic [11:0]         br_x_q;
   logic [11:0]         br_y_q;

   function automatic logic signed [31:0] smin(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [11:0] clamp(input logic signed [31:0] v,
                                         input logic signed [31:0] hi);
      if (v < 0)
         return 12'd0;
      else if (v > hi)
         return hi[11:0];
      else
         return v[11:0];
   endfunction

   logic [11:0] box_tl_x, box_tl_y, box_br_x, box_br_y;
   logic        box_degen;

   always_comb begin
      box_tl_x  = clamp(smin(smin(vtx_q[0], vtx_q[2]), vtx_q[4]), X_MAX);
      box_br_x  = clamp(smax(smax(vtx_q[0], vtx_q[2]), vtx_q[4]), X_MAX);
      box_tl_y  = clamp(smin(smin(vtx_q[1], vtx_q[3]), vtx_q[5]), Y_MAX);
      box_br_y  = clamp(smax(smax(vtx_q[1], vtx_q[3]), vtx_q[5]), Y_MAX);
      box_degen = (box_tl_x == box_br_x) || (box_tl_y == box_br_y);
   end

   // Vertex words sit at tri_idx*12 + {0,1,4,5,8,9}.
   logic [ADDR_W-1:0] tri_base;
   logic [ADDR_W-1:0] word_ofs;
   assign tri_base = ADDR_W'({tri_idx, 3'b000}) + ADDR_W'({tri_idx, 2'b00});
   assign word_ofs = ADDR_W'({fcnt[2:1], 1'b0, fcnt[0]});

   logic xfer, x_last, y_last;
   assign xfer   = pix_valid_q & bus.pix_ready;
   assign x_last = (pix_x_q == br_x_q - 12'd1);
   assign y_last = (pix_y_q == br_y_q - 12'd1);

`ifdef RASTER_SEQ_CLEAR_EN
   logic pix_clear_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         vtx_rd_q    <= 1'b0;
         vtx_addr_q  <= '0;
         rd_d        <= 1'b0;
         fcnt        <= '0;
         cap_idx     <= '0;
         for (int i = 0; i < 6; i++) vtx_q[i] <= '0;
         n_tri_q     <= '0;
         tri_idx     <= '0;
         color_q     <= C_INIT;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_color_q <= '0;
         tl_x_q      <= '0;
         br_x_q      <= '0;
         br_y_q      <= '0;
`ifdef RASTER_SEQ_CLEAR_EN
         pix_clear_q <= 1'b0;
`endif
      end else begin
         rd_d <= vtx_rd_q;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  busy_q  <= 1'b1;
                  n_tri_q <= bus.n_tri;
                  fcnt    <= '0;
                  cap_idx <= '0;
`ifdef RASTER_SEQ_CLEAR_EN
                  state       <= ST_CLEAR;
                  tl_x_q      <= '0;
                  br_x_q      <= 12'(FB_W);
                  br_y_q      <= 12'(FB_H);
                  pix_valid_q <= 1'b1;
                  pix_x_q     <= '0;
                  pix_y_q     <= '0;
                  pix_color_q <= C_INIT;
                  pix_clear_q <= 1'b1;
`else
                  state   <= ST_FETCH;
`endif
               end
            end

`ifdef RASTER_SEQ_CLEAR_EN
            ST_CLEAR: begin
               if (xfer) begin
                  if (x_last) begin
                     pix_x_q <= tl_x_q;
                     if (y_last) begin
                        pix_valid_q <= 1'b0;
                        pix_clear_q <= 1'b0;
                        state       <= ST_FETCH;
                     end else begin
                        pix_y_q <= pix_y_q + 12'd1;
                     end
                  end else begin
                     pix_x_q <= pix_x_q + 12'd1;
                  end
               end
            end
`endif

            ST_FETCH: begin
               if (fcnt == 3'd0 && tri_idx == n_tri_q) begin
                  state   <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  color_q <= C_INIT;
                  tri_idx <= '0;
               end else if (fcnt != 3'd6) begin
                  vtx_rd_q   <= 1'b1;
                  vtx_addr_q <= tri_base + word_ofs;
                  fcnt       <= fcnt + 3'd1;
               end else begin
                  vtx_rd_q   <= 1'b0;
               end
               // Data returns one cycle after each strobe; even words are x, odd are y.
               if (rd_d) begin
                  vtx_q[cap_idx] <= bus.vtx_rdata + (cap_idx[0] ? 32'(Y_OFS) : 32'(X_OFS));
                  cap_idx        <= cap_idx + 3'd1;
                  if (cap_idx == 3'd5)
                     state <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (box_degen) begin
                  state <= ST_NEXT;
               end else begin
                  tl_x_q      <= box_tl_x;
                  br_x_q      <= box_br_x;
                  br_y_q      <= box_br_y;
                  pix_valid_q <= 1'b1;
                  pix_x_q     <= box_tl_x;
                  pix_y_q     <= box_tl_y;
                  pix_color_q <= color_q;
                  state       <= ST_SCAN;
               end
            end

            ST_SCAN: begin
               if (xfer) begin
                  if (x_last) begin
                     pix_x_q <= tl_x_q;
                     if (y_last) begin
                        pix_valid_q <= 1'b0;
                        color_q     <= color_q + COLOR_W'(1);
                        state       <= ST_NEXT;
                     end else begin
                        pix_y_q <= pix_y_q + 12'd1;
                     end
                  end else begin
                     pix_x_q <= pix_x_q + 12'd1;
                  end
               end
            end

            ST_NEXT: begin
               tri_idx <= tri_idx + 16'd1;
               fcnt    <= '0;
               cap_idx <= '0;
               state   <= ST_FETCH;
            end

            ST_DONE: begin
               done_q <= 1'b0;
               state  <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.vtx_rd    = vtx_rd_q;
   assign bus.vtx_addr  = vtx_addr_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_x     = pix_x_q;
   assign bus.pix_y     = pix_y_q;
   assign bus.pix_color = pix_color_q;
`ifdef RASTER_SEQ_CLEAR_EN
   assign bus.pix_clear = pix_clear_q;
`else
   assign bus.pix_clear = 1'b0;
`endif
   assign bus.tri_v1x   = vtx_q[0];
   assign bus.tri_v1y   = vtx_q[1];
   assign bus.tri_v2x   = vtx_q[2];
   assign bus.tri_v2y   = vtx_q[3];
   assign bus.tri_v3x   = vtx_q[4];
   assign bus.tri_v3y   = vtx_q[5];

endmodule
